ysyx_24090003_lsu: RTL and testbench

Multi-cycle load/store unit sitting downstream of the execute stage. It consumes the execute stage's memory request (address, store data, size/sign funct, destination register) over a valid/ready handshake. It drives a word-addressed memory port with byte strobes. Load data is returned to the register file as a one-cycle write-back pulse.

---
 rtl/ysyx_24090003_lsu_pkg.sv | 38 +++
 rtl/ysyx_24090003_lsu_if.sv | 48 ++++
 rtl/ysyx_24090003_lsu_align.sv | 62 ++++++
 rtl/ysyx_24090003_lsu.sv | 159 +++++++++++++++
 tb/tb_ysyx_24090003_lsu.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24090003_lsu_pkg.sv
// rtl/ysyx_24090003_lsu_pkg.sv - shared funct3 codes, FSM state type and request checks for the LSU
// Purpose: constants and helpers imported by the LSU top and its lane-alignment block.
// Ports: none (package).
// Optional feature macro YSYX_24090003_LSU_MISALIGN_CHK_EN uses misaligned() from here.
package ysyx_24090003_lsu_pkg;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } lsu_state_t;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic funct_legal(input logic is_store, input logic [2:0] funct);
        if (is_store) begin
            return (funct == F_B) || (funct == F_H) || (funct == F_W);
        end
        return (funct == F_B) || (funct == F_H) || (funct == F_W) ||
               (funct == F_BU) || (funct == F_HU);
    endfunction

    // Only meaningful for legal functs; bytes can never be misaligned.
    function automatic logic misaligned(input logic [2:0] funct, input logic [1:0] off);
        case (funct)
            F_H, F_HU: return off[0];
            F_W:       return off != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24090003_lsu_if.sv
// rtl/ysyx_24090003_lsu_if.sv - request, memory-port and write-back signal bundle for the LSU
// Purpose: groups the execute-side request, the word-addressed memory port and the write-back outputs.
// Modports: master = the LSU (drives req_ready, mem_*, wb_*, lsu_done/lsu_err);
//           slave  = its environment (drives req_*, mem_ready, mem_resp_valid, mem_rdata).
interface ysyx_24090003_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct;
    logic [4:0]            req_rd;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;

    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_wen;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic [DATA_W-1:0]     wb_data;
    logic                  lsu_done;
    logic                  lsu_err;

    modport master (
        input  req_valid, req_is_store, req_funct, req_rd, req_addr, req_wdata,
        input  mem_ready, mem_resp_valid, mem_rdata,
        output req_ready,
        output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
        output wb_valid, wb_rd, wb_data, lsu_done, lsu_err
    );

    modport slave (
        output req_valid, req_is_store, req_funct, req_rd, req_addr, req_wdata,
        output mem_ready, mem_resp_valid, mem_rdata,
        input  req_ready,
        input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb,
        input  wb_valid, wb_rd, wb_data, lsu_done, lsu_err
    );

endinterface

// File: rtl/ysyx_24090003_lsu_align.sv
// rtl/ysyx_24090003_lsu_align.sv - byte-lane steering for stores and extraction/extension for loads
// Purpose: purely combinational lane logic for a 32-bit, 4-lane memory port.
// Ports: funct/off select the access; st_data -> st_wdata/st_wstrb (store side);
//        ld_word -> ld_data (load side, sign/zero extended).
// Unaligned halfword/word offsets are silently truncated here; rejecting them is the top's job.
module ysyx_24090003_lsu_align
    import ysyx_24090003_lsu_pkg::*;
(
    input  logic [2:0]  funct,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store: replicate the source into every lane so the strobe alone picks the target bytes.
    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
        case (funct[1:0])
            2'b00: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << {off[1], 1'b0};
            end
            default: begin
                st_wdata = st_data;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_word[7:0];
        case (off)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = off[1] ? ld_word[31:16] : ld_word[15:0];
    end

    always_comb begin
        ld_data = ld_word;
        case (funct)
            F_B:     ld_data = {{24{ld_byte[7]}}, ld_byte};
            F_BU:    ld_data = {24'd0, ld_byte};
            F_H:     ld_data = {{16{ld_half[15]}}, ld_half};
            F_HU:    ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/ysyx_24090003_lsu.sv
// rtl/ysyx_24090003_lsu.sv - multi-cycle load/store unit between execute and a word-addressed memory port
// Purpose: accepts one request at a time (IDLE -> REQ -> WAIT -> WB), drives the memory port with
//          byte strobes and returns load data as a one-cycle write-back pulse.
// Ports: cpu_clk (rising edge), cpu_rst (async, active-high), bus (ysyx_24090003_lsu_if.master).
// Optional feature: define YSYX_24090003_LSU_MISALIGN_CHK_EN to reject misaligned H/W accesses
//                   with lsu_err; otherwise low address bits are silently truncated.
module ysyx_24090003_lsu
    import ysyx_24090003_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    ysyx_24090003_lsu_if.master bus
);
    lsu_state_t        state, state_nxt;

    logic              is_store_q;
    logic [2:0]        funct_q;
    logic [4:0]        rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] ld_q;

    logic              done_q, err_q;
    logic              done_nxt, err_nxt, ld_capture;
    logic              idle_rdy, accept, req_ok;

    logic [31:0]       st_wdata, ld_data;
    logic [3:0]        st_wstrb;

    // The cycle carrying lsu_done is not ready yet, so back-to-back requests start one cycle later.
    assign idle_rdy = (state == IDLE) && !done_q && !cpu_rst;
    assign accept   = bus.req_valid && idle_rdy;

    always_comb begin
        req_ok = funct_legal(bus.req_is_store, bus.req_funct);
`ifdef YSYX_24090003_LSU_MISALIGN_CHK_EN
        if (misaligned(bus.req_funct, bus.req_addr[1:0])) begin
            req_ok = 1'b0;
        end
`endif
    end

    ysyx_24090003_lsu_align u_align (
        .funct    (funct_q),
        .off      (addr_q[1:0]),
        .st_data  (wdata_q),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_word  (bus.mem_rdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        ld_capture = 1'b0;

        bus.req_ready = idle_rdy;
        bus.mem_valid = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_ok) begin
                        state_nxt = REQ;
                    end else begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                    end
                end
            end
            REQ: begin
                // Response strobes are ignored here; only the ready handshake advances.
                bus.mem_valid = 1'b1;
                bus.mem_wen   = is_store_q;
                bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                if (is_store_q) begin
                    bus.mem_wdata = st_wdata;
                    bus.mem_wstrb = st_wstrb;
                end
                if (bus.mem_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    // Loads raise done together with the WB pulse; stores raise it in IDLE.
                    done_nxt = 1'b1;
                    if (is_store_q) begin
                        state_nxt = IDLE;
                    end else begin
                        ld_capture = 1'b1;
                        state_nxt  = WB;
                    end
                end
            end
            WB: begin
                bus.wb_valid = (rd_q != 5'd0);
                bus.wb_rd    = rd_q;
                bus.wb_data  = ld_q;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            is_store_q <= 1'b0;
            funct_q    <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (accept) begin
            is_store_q <= bus.req_is_store;
            funct_q    <= bus.req_funct;
            rd_q       <= bus.req_rd;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ld_q   <= '0;
        end else begin
            done_q <= done_nxt;
            err_q  <= err_nxt;
            if (ld_capture) begin
                ld_q <= ld_data;
            end
        end
    end

    assign bus.lsu_done = done_q;
    assign bus.lsu_err  = err_q;

endmodule

// File: tb/tb_ysyx_24090003_lsu.sv
// tb/tb_ysyx_24090003_lsu.sv - self-checking bench for ysyx_24090003_lsu with a behavioural memory model
module tb_ysyx_24090003_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_24090003_lsu_if bus ();

    ysyx_24090003_lsu dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] mem_arr [0:15];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    // Lane offset after truncating to the natural alignment of the access size.
    function automatic int lane(input logic [2:0] f, input logic [1:0] off);
        int o;
        o = off;
        return o - (o % nbytes(f));
    endfunction

    function automatic bit legal(input bit st, input logic [2:0] f, input logic [1:0] off);
        bit ok;
        int o;
        o  = off;
        ok = st ? (f <= 3'd2) : (f != 3'd3 && f != 3'd6 && f != 3'd7);
`ifdef YSYX_24090003_LSU_MISALIGN_CHK_EN
        if (ok && (o % nbytes(f)) != 0) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f, input logic [1:0] off);
        int nb;
        nb = nbytes(f);
        return 4'(((1 << nb) - 1) << lane(f, off));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f, input logic [31:0] wd);
        case (nbytes(f))
            1:       return (wd & 32'hFF) * 32'h01010101;
            2:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [1:0] off, input logic [31:0] word);
        logic [63:0] val, mask;
        int nb;
        nb   = nbytes(f);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        val  = ({32'd0, word} >> (8 * lane(f, off))) & mask;
        if (!f[2] && nb < 4 && ((val >> (8 * nb - 1)) & 64'd1) == 64'd1) val = val | ~mask;
        return val[31:0];
    endfunction

    task automatic run_req(input bit st, input logic [2:0] f, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int rdly, input int vdly);
        int idx;
        int waited;
        logic [31:0] wexp;
        logic [3:0]  sexp;
        idx    = int'(addr[5:2]);
        wexp   = exp_wdata(f, wd);
        sexp   = exp_strb(f, addr[1:0]);
        waited = 0;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct    = f;
        bus.req_rd       = rd;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;

        if (!legal(st, f, addr[1:0])) begin
            check("err_done", {31'd0, bus.lsu_done}, 32'd1);
            check("err_flag", {31'd0, bus.lsu_err}, 32'd1);
            check("err_no_mem", {31'd0, bus.mem_valid}, 32'd0);
            check("err_no_wb", {31'd0, bus.wb_valid}, 32'd0);
            @(negedge clk);
            check("err_done_pulse", {31'd0, bus.lsu_done}, 32'd0);
            check("err_flag_pulse", {31'd0, bus.lsu_err}, 32'd0);
            check("err_no_mem2", {31'd0, bus.mem_valid}, 32'd0);
            return;
        end

        for (int c = 0; c <= rdly; c++) begin
            check("req_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
            check("req_mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
            check("req_mem_wen", {31'd0, bus.mem_wen}, {31'd0, st});
            check("req_mem_wstrb", {28'd0, bus.mem_wstrb}, st ? {28'd0, sexp} : 32'd0);
            if (st) check("req_mem_wdata", bus.mem_wdata, wexp);
            check("req_busy", {31'd0, bus.req_ready}, 32'd0);
            bus.mem_ready      = (c == rdly);
            bus.mem_resp_valid = (c < rdly);
            bus.mem_rdata      = $urandom;
            @(negedge clk);
        end
        bus.mem_ready      = 1'b0;
        bus.mem_resp_valid = 1'b0;

        for (int c = 0; c <= vdly; c++) begin
            check("wait_mem_idle", {31'd0, bus.mem_valid}, 32'd0);
            check("wait_no_done", {31'd0, bus.lsu_done}, 32'd0);
            check("wait_busy", {31'd0, bus.req_ready}, 32'd0);
            bus.mem_resp_valid = (c == vdly);
            bus.mem_rdata      = st ? $urandom : mem_arr[idx];
            @(negedge clk);
        end
        bus.mem_resp_valid = 1'b0;

        check("done", {31'd0, bus.lsu_done}, 32'd1);
        check("done_no_err", {31'd0, bus.lsu_err}, 32'd0);
        check("wb_valid", {31'd0, bus.wb_valid}, {31'd0, (!st && rd != 5'd0)});
        if (!st && rd != 5'd0) begin
            check("wb_rd", {27'd0, bus.wb_rd}, {27'd0, rd});
            check("wb_data", bus.wb_data, exp_load(f, addr[1:0], mem_arr[idx]));
        end
        if (st) begin
            for (int b = 0; b < 4; b++) begin
                if (sexp[b]) mem_arr[idx][8*b +: 8] = wexp[8*b +: 8];
            end
        end
        @(negedge clk);
        check("done_pulse", {31'd0, bus.lsu_done}, 32'd0);
        check("wb_pulse", {31'd0, bus.wb_valid}, 32'd0);
        check("ready_after_done", {31'd0, bus.req_ready}, 32'd1);
    endtask

    // Start an LW, then reset while it sits in REQ (in_req=1) or in WAIT (in_req=0).
    task automatic reset_mid(input bit in_req);
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct    = 3'b010;
        bus.req_rd       = 5'd7;
        bus.req_addr     = 32'h8000_0010;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_pre_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
        if (!in_req) begin
            bus.mem_ready = 1'b1;
            @(negedge clk);
            bus.mem_ready = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("rst_done", {31'd0, bus.lsu_done}, 32'd0);
        check("rst_ready_low", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready_high", {31'd0, bus.req_ready}, 32'd1);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1111_2222;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_abandon_wb", {31'd0, bus.wb_valid}, 32'd0);
            check("rst_abandon_done", {31'd0, bus.lsu_done}, 32'd0);
        end
        bus.mem_resp_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req_valid      = 1'b0;
        bus.req_is_store   = 1'b0;
        bus.req_funct      = 3'b000;
        bus.req_rd         = 5'd0;
        bus.req_addr       = 32'd0;
        bus.req_wdata      = 32'd0;
        bus.mem_ready      = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'd0;
        for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;

        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, bus.req_ready}, 32'd0);
        check("reset_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("reset_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("reset_done", {31'd0, bus.lsu_done}, 32'd0);
        check("reset_err", {31'd0, bus.lsu_err}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);

        mem_arr[0] = 32'h80AA_BBCC;
        run_req(1'b0, 3'b000, 5'd5, 32'h8000_0003, 32'd0, 0, 0);
        run_req(1'b0, 3'b100, 5'd5, 32'h8000_0003, 32'd0, 0, 0);
        run_req(1'b1, 3'b001, 5'd9, 32'h8000_0102, 32'h1234_ABCD, 0, 0);
        check("sh_merged_word", mem_arr[0], 32'hABCD_BBCC);
        mem_arr[1] = 32'hDEAD_BEEF;
        run_req(1'b0, 3'b010, 5'd12, 32'h8000_0004, 32'd0, 3, 4);
        run_req(1'b0, 3'b011, 5'd4, 32'h8000_0008, 32'd0, 0, 0);
        run_req(1'b1, 3'b101, 5'd4, 32'h8000_0008, 32'hFFFF_FFFF, 0, 0);
        run_req(1'b0, 3'b010, 5'd0, 32'h8000_0004, 32'd0, 1, 0);
        reset_mid(1'b1);
        reset_mid(1'b0);
        run_req(1'b0, 3'b010, 5'd3, 32'h8000_0004, 32'd0, 0, 0);
        mem_arr[0] = 32'hCAFE_F00D;
        run_req(1'b0, 3'b010, 5'd6, 32'h8000_0002, 32'd0, 0, 0);
        run_req(1'b1, 3'b010, 5'd6, 32'h8000_0006, 32'h0BAD_CAFE, 0, 1);
        run_req(1'b0, 3'b101, 5'd8, 32'h8000_0023, 32'd0, 2, 0);

        for (int n = 0; n < 200; n++) begin
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    32'h8000_0000 + 32'($urandom_range(0, 63)), $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
